mem_ctrl: RTL and testbench
===========================

# mem_ctrl

CPU-side initiator of the byte-serial system memory bus. Accepts word/half/byte requests from the instruction-fetch unit and the load/store unit, serialises them into single-byte bus transactions on `mem_a`/`mem_wr`/`mem_dout`, and reassembles read bytes from `mem_din`. Sits inside `cpu`, directly driving its memory ports. Handles the bus pause (`rdy_in`) and back-pressure from the I/O transmit buffer.

## Interface
- `RAM_ADDR_WIDTH`, 17, address bit split; `a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11` selects I/O space.

- `clk_in` in 1: single clock, rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: 0 = bus owned by host; freeze.
- `mem_din` in 8: read byte. Valid one cycle after its address.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: I/O transmit buffer full.
- `if_req` in 1: fetch request, level, held until `if_ready`.
- `if_addr` in 32: fetch address, always 4 bytes.
- `if_ready` out 1: one-cycle pulse, `if_data` valid.
- `if_data` out 32: fetched word, little-endian.
- `ls_req` in 1: load/store request, level, held until `ls_done`.
- `ls_we` in 1: 1 = store.
- `ls_size` in 2: 0 byte, 1 half, 2 word; 3 is illegal and treated as word.
- `ls_addr` in 32, `ls_wdata` in 32: address and store data (low bytes used).
- `ls_done` out 1: one-cycle pulse.
- `ls_rdata` out 32: load bytes zero-extended. Sign extension is the LSU's job.
- `flush` in 1: abort pending fetch/load (branch mispredict).

## Operation
- States: IDLE, READ, WRITE. N = bytes of current request (4 for fetch).
- IDLE arbitration:
  - `ls_req` has priority over `if_req`.
  - A request is not accepted in a cycle with `flush`=1.
- READ:
  - Issue addresses base+0..base+N-1, one per cycle, with `mem_wr`=0.
  - Capture byte i from `mem_din` one cycle after its issue into lane i.
  - After the last capture, pulse done with data and return to IDLE.
- WRITE:
  - Drive base+i, byte lane i of `ls_wdata`, `mem_wr`=1, one byte per cycle.
  - Pulse `ls_done` the cycle after the last byte.
- I/O write stall: if the address is I/O and `io_buffer_full`=1, the byte is not written (`mem_wr`=0). The same byte retries next cycle.
- `rdy_in`=0:
  - No state, counter or output-register change.
  - `mem_wr` forced 0.
  - On resume, any read byte issued but not captured is re-issued. The issue pointer is reset to the capture pointer.
- `flush`=1:
  - An in-flight READ (fetch or load) goes to IDLE next cycle, with no done pulse and partial data discarded.
  - An in-flight WRITE is never aborted and completes normally.
- Outside READ/WRITE: `mem_wr`=0, `mem_a`=0, `mem_dout`=0.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-operation: IDLE on the next edge; `mem_wr`=0 from that cycle; request dropped.

## Timing
- Cycle 0 = IDLE cycle in which the request is sampled high.
- Read: addresses in cycles 1..N; byte i on `mem_din` in cycle i+2; done pulse plus data in cycle N+2.
  - Word: done in cycle 6. Byte: done in cycle 3.
- Write: bytes in cycles 1..N; `ls_done` in cycle N+1.
- Done cycle returns to IDLE. A new request can be sampled in that same cycle (back-to-back); the requester must drop or change `*_req` by then.
- Every stall cycle (`rdy_in`=0 or I/O full) adds exactly one cycle. A read stall adds one further cycle per re-issued byte.
- All outputs registered; no combinational path from inputs to `mem_*`.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE/READ/WRITE)
  - size codes `SZ_B/SZ_H/SZ_W`
  - `IO_SEL=2'b11`
  - function `is_io(addr)`.
- Single module, no sub-module. Byte assembly is a 4-lane shift register with a 3-bit issue pointer and a 3-bit capture pointer.

## Test plan
- Word fetch, RAM[0..3]=93,00,00,00: `mem_a` 0,1,2,3 in cycles 1–4; `if_ready` cycle 6; `if_data`=0x00000093.
- Fetch and word-load of 0x1000 requested together: load served first, `ls_done` cycle 6; fetch starts cycle 6, `if_ready` cycle 12.
- Store half 0xBEEF to 0x0102: (0x102, EF, wr=1), (0x103, BE, wr=1); `ls_done` cycle 3; `mem_wr`=0 in cycle 3.
- Store byte 0x41 to 0x30000 with `io_buffer_full` high cycles 1–3: `mem_wr`=0 cycles 1–3; write in cycle 4; `ls_done` cycle 5.
- Word read of 0x2000 with `rdy_in` low in cycles 2–3: `mem_wr` never 1; uncaptured byte re-issued; `ls_rdata` matches RAM.
- Boundary cases:
  - `flush` in cycle 3 of a fetch: no `if_ready`; IDLE in cycle 4.
  - `flush` during a word store: all 4 bytes written.
  - `rst_in` during a store: `mem_wr`=0 next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-serial memory bus controller.
package mem_pkg;

  localparam int RAM_ADDR_WIDTH = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] IO_SEL = 2'b11;

  // Top two address bits of the RAM window select the I/O space.
  function automatic logic is_io(input logic [31:0] addr);
    return addr[RAM_ADDR_WIDTH -: 2] == IO_SEL;
  endfunction

  // Byte count of a load/store; the unused code 3 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory bus initiator: serialises fetch and load/store requests into
// single-byte bus cycles and reassembles read bytes little-endian.
//
// state | meaning
// IDLE  | bus quiet, arbitrating ls_req over if_req
// READ  | issuing read addresses and capturing returned bytes
// WRITE | driving one store byte per cycle until all are written
module mem_ctrl
  import mem_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        flush
);

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  iss_q, iss_d;       // read: addresses issued; write: byte on the bus
  logic [2:0]  cap_q, cap_d;       // read bytes captured
  logic        shown_q, shown_d;   // mem_a carries a fresh read address this cycle
  logic        pend_q, pend_d;     // mem_din answers our previous address
  logic        resume_q, resume_d; // a read was frozen; re-issue from cap_q
  logic        fetch_q, fetch_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        wr_q, wr_d;
  logic        if_ready_q, if_ready_d;
  logic [31:0] if_data_q, if_data_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        io_stall;
  logic [31:0] captured;
  logic [31:0] aligned;
  logic [5:0]  shamt;
  logic [1:0]  lane;

  // An I/O byte is held off the bus while the transmit buffer is full.
  assign io_stall = wr_q && is_io(mem_a_q) && io_buffer_full;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    n_d        = n_q;
    iss_d      = iss_q;
    cap_d      = cap_q;
    shown_d    = shown_q;
    pend_d     = pend_q;
    resume_d   = resume_q;
    fetch_d    = fetch_q;
    buf_d      = buf_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    wr_d       = wr_q;
    if_ready_d = 1'b0;
    if_data_d  = if_data_q;
    ls_done_d  = 1'b0;
    ls_rdata_d = ls_rdata_q;
    captured   = {mem_din, buf_q[31:8]};
    shamt      = {3'd4 - n_q, 3'b000};
    aligned    = captured >> shamt;
    lane       = iss_q[1:0] + 2'd1;

    if (!rdy_in) begin
      if (state_q == READ) resume_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!flush && ls_req) begin
            base_d   = ls_addr;
            n_d      = size_bytes(ls_size);
            cap_d    = 3'd0;
            buf_d    = 32'd0;
            fetch_d  = 1'b0;
            resume_d = 1'b0;
            mem_a_d  = ls_addr;
            if (ls_we) begin
              state_d    = WRITE;
              wdata_d    = ls_wdata;
              iss_d      = 3'd0;
              mem_dout_d = ls_wdata[7:0];
              wr_d       = 1'b1;
            end else begin
              state_d = READ;
              iss_d   = 3'd1;
              shown_d = 1'b1;
              pend_d  = 1'b0;
            end
          end else if (!flush && if_req) begin
            state_d  = READ;
            base_d   = if_addr;
            n_d      = 3'd4;
            cap_d    = 3'd0;
            buf_d    = 32'd0;
            fetch_d  = 1'b1;
            resume_d = 1'b0;
            iss_d    = 3'd1;
            shown_d  = 1'b1;
            pend_d   = 1'b0;
            mem_a_d  = if_addr;
          end
        end
        READ: begin
          if (flush) begin
            state_d  = IDLE;
            mem_a_d  = 32'd0;
            shown_d  = 1'b0;
            pend_d   = 1'b0;
            resume_d = 1'b0;
          end else if (resume_q) begin
            // Bytes answered while the host owned the bus are unreliable.
            resume_d = 1'b0;
            pend_d   = 1'b0;
            shown_d  = 1'b1;
            mem_a_d  = base_q + 32'(cap_q);
            iss_d    = cap_q + 3'd1;
          end else begin
            pend_d = shown_q;
            if (iss_q < n_q) begin
              mem_a_d = base_q + 32'(iss_q);
              iss_d   = iss_q + 3'd1;
              shown_d = 1'b1;
            end else begin
              shown_d = 1'b0;
            end
            if (pend_q) begin
              buf_d = captured;
              cap_d = cap_q + 3'd1;
              if (cap_q == n_q - 3'd1) begin
                state_d = IDLE;
                mem_a_d = 32'd0;
                shown_d = 1'b0;
                pend_d  = 1'b0;
                if (fetch_q) begin
                  if_ready_d = 1'b1;
                  if_data_d  = aligned;
                end else begin
                  ls_done_d  = 1'b1;
                  ls_rdata_d = aligned;
                end
              end
            end
          end
        end
        WRITE: begin
          if (!io_stall) begin
            if (iss_q == n_q - 3'd1) begin
              state_d    = IDLE;
              ls_done_d  = 1'b1;
              wr_d       = 1'b0;
              mem_a_d    = 32'd0;
              mem_dout_d = 8'd0;
            end else begin
              iss_d      = iss_q + 3'd1;
              mem_a_d    = base_q + 32'(iss_q + 3'd1);
              mem_dout_d = wdata_q[{lane, 3'b000} +: 8];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      n_q        <= 3'd0;
      iss_q      <= 3'd0;
      cap_q      <= 3'd0;
      shown_q    <= 1'b0;
      pend_q     <= 1'b0;
      resume_q   <= 1'b0;
      fetch_q    <= 1'b0;
      buf_q      <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      wr_q       <= 1'b0;
      if_ready_q <= 1'b0;
      if_data_q  <= 32'd0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      n_q        <= n_d;
      iss_q      <= iss_d;
      cap_q      <= cap_d;
      shown_q    <= shown_d;
      pend_q     <= pend_d;
      resume_q   <= resume_d;
      fetch_q    <= fetch_d;
      buf_q      <= buf_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      wr_q       <= wr_d;
      if_ready_q <= if_ready_d;
      if_data_q  <= if_data_d;
      ls_done_q  <= ls_done_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // The write strobe is the only output gated by the host pause and I/O stall.
  assign mem_wr   = wr_q && rdy_in && !io_stall;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign if_ready = if_ready_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide RAM and I/O sink model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_ready;
  logic [31:0] if_data;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = 2'd0;
  logic [31:0] ls_addr = 32'd0;
  logic [31:0] ls_wdata = 32'd0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        flush = 1'b0;

  int errors = 0;
  int checks = 0;

  bit [7:0] ram_w [0:65535];
  bit       ram_v [0:65535];
  int       io_cnt = 0;
  logic [7:0] io_byte = 8'd0;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .flush(flush)
  );

  function automatic logic [7:0] preload(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h93;
      16'h0004: return 8'h13;
      16'h0005: return 8'h05;
      16'h1000: return 8'h11;
      16'h1001: return 8'h22;
      16'h1002: return 8'h33;
      16'h1003: return 8'h44;
      16'h2000: return 8'hA1;
      16'h2001: return 8'hB2;
      16'h2002: return 8'hC3;
      16'h2003: return 8'hD4;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [15:0] a);
    return ram_v[a] ? ram_w[a] : preload(a);
  endfunction

  // Memory answers one cycle after the address; garbage if the host owned the bus.
  always @(posedge clk_in) begin
    mem_din <= rdy_in ? ram_rd(mem_a[15:0]) : 8'hEE;
    if (mem_wr) begin
      if (mem_a[17:16] == 2'b11) begin
        io_cnt  <= io_cnt + 1;
        io_byte <= mem_dout;
      end else begin
        ram_w[mem_a[15:0]] <= mem_dout;
        ram_v[mem_a[15:0]] <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0;
    ls_req = 1'b0;
    flush  = 1'b0;
    rdy_in = 1'b1;
    io_buffer_full = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int done_cyc;
    int done2_cyc;
    int pulses;
    logic [31:0] got;
    logic [31:0] got2;
    logic saw_wr;

    // Reset
    step(); step(); #1;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_done", 32'(ls_done), 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst_in = 1'b0;

    // Word fetch from 0
    step(); if_req = 1'b1; if_addr = 32'h0;
    pulses = 0; done_cyc = 0; got = 32'd0;
    for (int c = 1; c <= 8; c++) begin
      step(); #1;
      if (c <= 4) chk("fetch_addr", mem_a, 32'(c - 1));
      if (c == 6) chk("fetch_idle_addr", mem_a, 32'd0);
      if (if_ready) begin pulses++; done_cyc = c; got = if_data; if_req = 1'b0; end
    end
    chk("fetch_pulses", 32'(pulses), 32'd1);
    chk("fetch_ready_cycle", 32'(done_cyc), 32'd6);
    chk("fetch_data", got, 32'h00000093);
    idle(4);

    // Simultaneous load and fetch: load wins
    step(); ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h1000;
    if_req = 1'b1; if_addr = 32'h4;
    done_cyc = 0; done2_cyc = 0; got = 32'd0; got2 = 32'd0;
    for (int c = 1; c <= 14; c++) begin
      step(); #1;
      if (c == 1) chk("arb_first_addr", mem_a, 32'h1000);
      if (c == 7) chk("arb_fetch_addr", mem_a, 32'h4);
      if (ls_done) begin done_cyc = c; got = ls_rdata; ls_req = 1'b0; end
      if (if_ready) begin done2_cyc = c; got2 = if_data; if_req = 1'b0; end
    end
    chk("arb_ls_cycle", 32'(done_cyc), 32'd6);
    chk("arb_ls_data", got, 32'h44332211);
    chk("arb_if_cycle", 32'(done2_cyc), 32'd12);
    chk("arb_if_data", got2, 32'h00000513);
    idle(4);

    // Byte load, zero-extended
    step(); ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h1002;
    done_cyc = 0; got = 32'd0;
    for (int c = 1; c <= 6; c++) begin
      step(); #1;
      if (c == 1) chk("lb_addr", mem_a, 32'h1002);
      if (ls_done) begin done_cyc = c; got = ls_rdata; ls_req = 1'b0; end
    end
    chk("lb_cycle", 32'(done_cyc), 32'd3);
    chk("lb_data", got, 32'h00000033);
    idle(4);

    // Half store 0xBEEF to 0x102
    step(); ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h102;
    ls_wdata = 32'h1234BEEF;
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      if (c == 1) begin
        chk("sh_a0", mem_a, 32'h102);
        chk("sh_d0", 32'(mem_dout), 32'hEF);
        chk("sh_wr0", 32'(mem_wr), 32'd1);
      end
      if (c == 2) begin
        chk("sh_a1", mem_a, 32'h103);
        chk("sh_d1", 32'(mem_dout), 32'hBE);
        chk("sh_wr1", 32'(mem_wr), 32'd1);
      end
      if (c == 3) begin
        chk("sh_done", 32'(ls_done), 32'd1);
        chk("sh_wr_after", 32'(mem_wr), 32'd0);
      end
      if (ls_done) ls_req = 1'b0;
    end
    chk("sh_ram", {16'd0, ram_rd(16'h0103), ram_rd(16'h0102)}, 32'h0000BEEF);
    chk("sh_no_spill", {30'd0, ram_v[16'h0104], ram_v[16'h0101]}, 32'd0);
    idle(4);

    // I/O byte store with transmit buffer full in cycles 1-3
    step(); ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h30000;
    ls_wdata = 32'h00000041;
    done_cyc = 0;
    for (int c = 1; c <= 7; c++) begin
      step();
      io_buffer_full = (c <= 3);
      #1;
      if (c <= 3) chk("io_blocked", 32'(mem_wr), 32'd0);
      if (c == 4) begin
        chk("io_write", 32'(mem_wr), 32'd1);
        chk("io_byte_out", 32'(mem_dout), 32'h41);
      end
      if (ls_done) begin done_cyc = c; ls_req = 1'b0; end
    end
    chk("io_done_cycle", 32'(done_cyc), 32'd5);
    chk("io_count", 32'(io_cnt), 32'd1);
    chk("io_sink_byte", 32'(io_byte), 32'h41);
    idle(4);

    // Word load of 0x2000 with host pause in cycles 2-3
    step(); ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h2000;
    saw_wr = 1'b0; pulses = 0; done_cyc = 0; got = 32'd0;
    for (int c = 1; c <= 14; c++) begin
      step();
      rdy_in = !(c == 2 || c == 3);
      #1;
      if (mem_wr) saw_wr = 1'b1;
      if (c == 3) chk("stall_hold_addr", mem_a, 32'h2001);
      if (c == 5) chk("reissue_addr", mem_a, 32'h2000);
      if (ls_done) begin pulses++; done_cyc = c; got = ls_rdata; ls_req = 1'b0; end
    end
    chk("stall_no_write", 32'(saw_wr), 32'd0);
    chk("stall_pulses", 32'(pulses), 32'd1);
    chk("stall_done_cycle", 32'(done_cyc), 32'd10);
    chk("stall_data", got, 32'hD4C3B2A1);
    idle(4);

    // Flush in cycle 3 of a fetch
    step(); if_req = 1'b1; if_addr = 32'h0;
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 3) begin flush = 1'b1; if_req = 1'b0; end
      if (c == 4) flush = 1'b0;
      #1;
      if (c == 3) chk("flush_busy_addr", mem_a, 32'h2);
      if (c == 4) chk("flush_idle_addr", mem_a, 32'd0);
      if (if_ready) pulses++;
    end
    chk("flush_no_ready", 32'(pulses), 32'd0);
    idle(4);

    // Flush in the request cycle delays acceptance by one cycle
    step(); if_req = 1'b1; if_addr = 32'h1000; flush = 1'b1;
    done_cyc = 0; got = 32'd0;
    for (int c = 1; c <= 10; c++) begin
      step();
      flush = 1'b0;
      #1;
      if (c == 1) chk("flush_req_blocked", mem_a, 32'd0);
      if (c == 2) chk("flush_req_late", mem_a, 32'h1000);
      if (if_ready) begin done_cyc = c; got = if_data; if_req = 1'b0; end
    end
    chk("flush_req_cycle", 32'(done_cyc), 32'd7);
    chk("flush_req_data", got, 32'h44332211);
    idle(4);

    // Flush during a word store (size code 3) does not abort it
    step(); ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd3; ls_addr = 32'h4000;
    ls_wdata = 32'hCAFEF00D;
    done_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      flush = (c <= 3);
      #1;
      if (ls_done) begin done_cyc = c; ls_req = 1'b0; end
    end
    chk("sw_flush_cycle", 32'(done_cyc), 32'd5);
    chk("sw_flush_ram", {ram_rd(16'h4003), ram_rd(16'h4002), ram_rd(16'h4001), ram_rd(16'h4000)},
        32'hCAFEF00D);
    idle(4);

    // Reset in the middle of a store
    step(); ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h5000;
    ls_wdata = 32'h11223344;
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) begin rst_in = 1'b1; ls_req = 1'b0; end
      if (c == 3) rst_in = 1'b0;
      #1;
      if (c == 1) chk("rst_store_wr", 32'(mem_wr), 32'd1);
      if (c == 3) begin
        chk("rst_store_wr_off", 32'(mem_wr), 32'd0);
        chk("rst_store_addr", mem_a, 32'd0);
      end
      if (c == 4) chk("rst_store_wr_off2", 32'(mem_wr), 32'd0);
      if (ls_done) pulses++;
    end
    chk("rst_store_no_done", 32'(pulses), 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
